mips_hazard_ctrl: RTL and testbench
===================================

Name: mips_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline (F/D/X/M/W).
- Generates ALU-operand forwarding selects for the X stage.
- Inserts load-use interlock bubbles; bubble count is configurable for deeper data-memory reads.
- Flushes younger stages on a branch/jump redirect resolved in X.
- Supports a no-forwarding mode that resolves RAW hazards by stalling.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register-address width
LU_STALL_CYC, 1, bubbles inserted per load-use hazard (legal 1..4)
FWD_EN, 1, 1 = forwarding enabled; 0 = RAW hazards resolved by stalls only
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
rs1_d  in  REG_ADDR_W  rs of instruction in D
rs2_d  in  REG_ADDR_W  rt of instruction in D
use_rs1_d  in  1  D instruction reads rs
use_rs2_d  in  1  D instruction reads rt
rs1_x  in  REG_ADDR_W  rs of instruction in X
rs2_x  in  REG_ADDR_W  rt of instruction in X
rd_x  in  REG_ADDR_W  destination register, X
rd_m  in  REG_ADDR_W  destination register, M
rd_w  in  REG_ADDR_W  destination register, W
regwrite_x  in  1  X writes the register file
regwrite_m  in  1  M writes the register file
regwrite_w  in  1  W writes the register file
memread_x  in  1  instruction in X is a load
redirect_x  in  1  taken branch or jump resolved in X
cnt_clr  in  1  synchronous clear of both counters
fwd_a_sel  out  2  ALU A source: 0 = regfile, 1 = M ALU result, 2 = W writeback data
fwd_b_sel  out  2  ALU B (and store-data) source, same encoding
stall_f  out  1  hold PC
stall_d  out  1  hold F/D register
flush_d  out  1  clear F/D register to NOP
flush_x  out  1  clear D/X register to bubble (all control flags 0)
stall_cnt  out  CNT_W  cycles with stall_d=1, saturating
flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
Reset:
- Reset is asynchronous and active-low on rst.
- While rst=0: FSM=IDLE, internal counter=0, stall_cnt=0, flush_cnt=0, and all outputs forced to 0.

Forwarding (combinational, FWD_EN=1; with FWD_EN=0 both selects are tied to 0):
- fwd_a_sel=1 if regwrite_m && rd_m!=0 && rd_m==rs1_x.
- Otherwise fwd_a_sel=2 if regwrite_w && rd_w!=0 && rd_w==rs1_x.
- Otherwise fwd_a_sel=0.
- fwd_b_sel: same rules using rs2_x.
- M has priority over W. Register 0 is never forwarded.

RAW match definition:
- match(rd, we) = we && rd!=0 && ((use_rs1_d && rs1_d==rd) || (use_rs2_d && rs2_d==rd)).

Hazard detection:
- lu_hit (FWD_EN=1) = memread_x && match(rd_x, regwrite_x).
- raw_hit (FWD_EN=0) = match(rd_x, regwrite_x) || match(rd_m, regwrite_m) || match(rd_w, regwrite_w).
- The register file does not bypass, so an rd_w match still stalls.
- raw_hit stalls combinationally, one cycle per occurrence, re-evaluated every cycle. It uses no FSM state.

FSM (FWD_EN=1):
- States: IDLE, LU_STALL.
- IDLE: on lu_hit && !redirect_x, assert stall_f, stall_d and flush_x in that cycle.
  - If LU_STALL_CYC>1, load cnt=LU_STALL_CYC-2 and go to LU_STALL.
  - Otherwise stay in IDLE.
- LU_STALL: assert stall_f, stall_d and flush_x. If cnt==0, go to IDLE; otherwise decrement cnt.
- Total bubbles per load-use = exactly LU_STALL_CYC.
- New lu_hit detections are ignored while in LU_STALL; X holds a bubble during that time.

Redirect:
- redirect_x=1 asserts flush_d=1 and flush_x=1 in the same cycle.
- It forces stall_f=stall_d=0 so the PC loads the target.
- Redirect has priority over every stall source. If it coincides with lu_hit or raw_hit, no stall occurs and the FSM goes or stays IDLE.

Counters:
- stall_cnt increments on each cycle with stall_d=1.
- flush_cnt increments on each cycle with redirect_x=1.
- Both saturate at all-ones; no wrap.
- cnt_clr has priority over increment; counter=0 on the next edge.

Latency:
- Selects, stall and flush outputs are combinational from inputs plus FSM state.
- Counters update on the edge after the event.

Test Plan:
1. Forwarding priority: FWD_EN=1; rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_x=5 -> fwd_a_sel=1. Drop regwrite_m -> fwd_a_sel=2. Set rs1_x=0 with rd_m=0 -> fwd_a_sel=0.
2. Load-use: LU_STALL_CYC=3; memread_x=1, rd_x=8, regwrite_x=1, rs2_d=8, use_rs2_d=1 for one cycle -> stall_f/stall_d/flush_x high for exactly 3 cycles, then low; stall_cnt=3.
3. Redirect beats stall: lu_hit and redirect_x both asserted in the same cycle -> stall_d=0, flush_d=flush_x=1, FSM stays IDLE, flush_cnt increments by 1, stall_cnt unchanged.
4. No-forward mode: FWD_EN=0; rd_x=3 writer with rs1_d=3, use_rs1_d=1, writer advances X->M->W -> stall_d high 3 consecutive cycles, fwd selects always 0. Repeat with rd=0 -> no stall.
5. Reset mid-stall: LU_STALL_CYC=4, drop rst in the 2nd bubble cycle -> all outputs 0 immediately (asynchronous). After release, FSM=IDLE and no residual bubbles.
6. Saturation/clear: CNT_W=4; hold a stall for 20 cycles -> stall_cnt=15 and stays 15. Pulse cnt_clr with a stall active -> stall_cnt=0 on the next edge.

Source files
------------

// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl: hazard and forwarding controller for a 5-stage MIPS pipeline.
//   Inputs : clk, rst (async active-low), D-stage sources (rs1_d/rs2_d + use flags),
//            X-stage sources (rs1_x/rs2_x), destinations rd_x/rd_m/rd_w with
//            regwrite flags, memread_x, redirect_x, cnt_clr.
//   Outputs: fwd_a_sel/fwd_b_sel (0 regfile, 1 M result, 2 W data), stall_f, stall_d,
//            flush_d, flush_x, saturating stall_cnt / flush_cnt.
module mips_hazard_ctrl #(
   parameter int REG_ADDR_W   = 5,
   parameter int LU_STALL_CYC = 1,
   parameter int FWD_EN       = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic                  use_rs1_d,
   input  logic                  use_rs2_d,
   input  logic [REG_ADDR_W-1:0] rs1_x,
   input  logic [REG_ADDR_W-1:0] rs2_x,
   input  logic [REG_ADDR_W-1:0] rd_x,
   input  logic [REG_ADDR_W-1:0] rd_m,
   input  logic [REG_ADDR_W-1:0] rd_w,
   input  logic                  regwrite_x,
   input  logic                  regwrite_m,
   input  logic                  regwrite_w,
   input  logic                  memread_x,
   input  logic                  redirect_x,
   input  logic                  cnt_clr,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_x,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);
   typedef enum logic {IDLE, LU_STALL} state_t;
   state_t state, stateNext;
   logic [2:0] cnt, cntNext;
   logic luHit, rawHit, stallReq;
   function automatic logic rawMatch(input logic [REG_ADDR_W-1:0] rd, input logic we);
      return we && rd != '0 && ((use_rs1_d && rs1_d == rd) || (use_rs2_d && rs2_d == rd));
   endfunction
   // M result is younger than W data, so it wins; r0 is hardwired and never forwarded
   function automatic logic [1:0] fwdSel(input logic [REG_ADDR_W-1:0] rs);
      return (regwrite_m && rd_m != '0 && rd_m == rs) ? 2'd1 :
             (regwrite_w && rd_w != '0 && rd_w == rs) ? 2'd2 : 2'd0;
   endfunction
   always_comb begin
      luHit     = (FWD_EN != 0) && memread_x && rawMatch(rd_x, regwrite_x);
      // without a regfile bypass even a W-stage writer must be waited out
      rawHit    = (FWD_EN == 0) && (rawMatch(rd_x, regwrite_x) || rawMatch(rd_m, regwrite_m) ||
                                    rawMatch(rd_w, regwrite_w));
      stateNext = state;
      cntNext   = cnt;
      stallReq  = 1'b0;
      if (state == LU_STALL) begin
         stallReq = 1'b1;
         if (cnt == '0) stateNext = IDLE;
         else cntNext = cnt - 3'd1;
      end else if (luHit) begin
         stallReq = 1'b1;
         if (LU_STALL_CYC > 1) begin
            stateNext = LU_STALL;
            cntNext   = 3'(LU_STALL_CYC - 2);
         end
      end
      if (rawHit) stallReq = 1'b1;
      // a redirect kills the stalled instruction anyway, so let the PC take the target
      if (redirect_x) begin
         stallReq  = 1'b0;
         stateNext = IDLE;
         cntNext   = '0;
      end
   end
   assign fwd_a_sel = (rst && FWD_EN != 0) ? fwdSel(rs1_x) : 2'd0;
   assign fwd_b_sel = (rst && FWD_EN != 0) ? fwdSel(rs2_x) : 2'd0;
   assign stall_f   = rst && stallReq;
   assign stall_d   = rst && stallReq;
   assign flush_d   = rst && redirect_x;
   assign flush_x   = rst && (redirect_x || stallReq);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         stall_cnt <= cnt_clr ? '0 : (stall_d && stall_cnt != '1) ? stall_cnt + CNT_W'(1) : stall_cnt;
         flush_cnt <= cnt_clr ? '0 : (redirect_x && flush_cnt != '1) ? flush_cnt + CNT_W'(1) : flush_cnt;
      end
   end
endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// tb_mips_hazard_ctrl: three configurations of mips_hazard_ctrl against a bubble-count reference model.
module tb_mips_hazard_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w;
   logic use_rs1_d, use_rs2_d, regwrite_x, regwrite_m, regwrite_w, memread_x, redirect_x, cnt_clr;
   logic [1:0] fa [3];
   logic [1:0] fb [3];
   logic sf [3];
   logic sd [3];
   logic fd [3];
   logic fx [3];
   logic [15:0] scA, fcA;
   logic [3:0] scB, fcB, scC, fcC;
   localparam int LU  [3] = '{3, 1, 4};
   localparam int FWD [3] = '{1, 0, 1};
   localparam int CW  [3] = '{16, 4, 4};
   int checks = 0;
   int failures = 0;
   int left [3];
   int sCnt [3];
   int fCnt [3];
   int nLeft [3];
   int nS [3];
   int nF [3];

   mips_hazard_ctrl #(.REG_ADDR_W(5), .LU_STALL_CYC(3), .FWD_EN(1), .CNT_W(16)) dutA (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .rd_m(rd_m), .rd_w(rd_w), .regwrite_x(regwrite_x),
      .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memread_x(memread_x), .redirect_x(redirect_x),
      .cnt_clr(cnt_clr), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]), .stall_f(sf[0]), .stall_d(sd[0]),
      .flush_d(fd[0]), .flush_x(fx[0]), .stall_cnt(scA), .flush_cnt(fcA));
   mips_hazard_ctrl #(.REG_ADDR_W(5), .LU_STALL_CYC(1), .FWD_EN(0), .CNT_W(4)) dutB (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .rd_m(rd_m), .rd_w(rd_w), .regwrite_x(regwrite_x),
      .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memread_x(memread_x), .redirect_x(redirect_x),
      .cnt_clr(cnt_clr), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]), .stall_f(sf[1]), .stall_d(sd[1]),
      .flush_d(fd[1]), .flush_x(fx[1]), .stall_cnt(scB), .flush_cnt(fcB));
   mips_hazard_ctrl #(.REG_ADDR_W(5), .LU_STALL_CYC(4), .FWD_EN(1), .CNT_W(4)) dutC (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .rs1_x(rs1_x), .rs2_x(rs2_x), .rd_x(rd_x), .rd_m(rd_m), .rd_w(rd_w), .regwrite_x(regwrite_x),
      .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .memread_x(memread_x), .redirect_x(redirect_x),
      .cnt_clr(cnt_clr), .fwd_a_sel(fa[2]), .fwd_b_sel(fb[2]), .stall_f(sf[2]), .stall_d(sd[2]),
      .flush_d(fd[2]), .flush_x(fx[2]), .stall_cnt(scC), .flush_cnt(fcC));

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic string tg(input string s, input int i);
      return $sformatf("%s_%0d", s, i);
   endfunction

   function automatic bit hit(input logic [4:0] rd, input logic we);
      return we && rd != 0 && ((use_rs1_d && rs1_d == rd) || (use_rs2_d && rs2_d == rd));
   endfunction

   function automatic int fsel(input logic [4:0] rs);
      if (regwrite_m && rd_m != 0 && rd_m == rs) return 1;
      if (regwrite_w && rd_w != 0 && rd_w == rs) return 2;
      return 0;
   endfunction

   task automatic idle();
      {rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m, rd_w} = '0;
      {use_rs1_d, use_rs2_d, regwrite_x, regwrite_m, regwrite_w, memread_x, redirect_x, cnt_clr} = '0;
   endtask

   task automatic loadUse();
      memread_x = 1'b1; rd_x = 5'd8; regwrite_x = 1'b1; rs2_d = 5'd8; use_rs2_d = 1'b1;
   endtask

   // checks every output of every instance for the inputs applied, then advances one clock
   task automatic cycle();
      int sc [3];
      int fc [3];
      bit lu, raw, st;
      int mx;
      #1;
      sc = '{int'(scA), int'(scB), int'(scC)};
      fc = '{int'(fcA), int'(fcB), int'(fcC)};
      for (int i = 0; i < 3; i++) begin
         lu  = memread_x && hit(rd_x, regwrite_x);
         raw = hit(rd_x, regwrite_x) || hit(rd_m, regwrite_m) || hit(rd_w, regwrite_w);
         if (!rst) begin left[i] = 0; sCnt[i] = 0; fCnt[i] = 0; end
         st = rst && !redirect_x && (FWD[i] != 0 ? (left[i] > 0 || lu) : raw);
         check(tg("fwd_a", i), fa[i], (rst && FWD[i] != 0) ? fsel(rs1_x) : 0);
         check(tg("fwd_b", i), fb[i], (rst && FWD[i] != 0) ? fsel(rs2_x) : 0);
         check(tg("stall_f", i), sf[i], st);
         check(tg("stall_d", i), sd[i], st);
         check(tg("flush_d", i), fd[i], rst && redirect_x);
         check(tg("flush_x", i), fx[i], rst && (redirect_x || st));
         check(tg("stall_cnt", i), sc[i], sCnt[i]);
         check(tg("flush_cnt", i), fc[i], fCnt[i]);
         mx = (1 << CW[i]) - 1;
         nLeft[i] = (FWD[i] == 0 || redirect_x) ? 0 : left[i] > 0 ? left[i] - 1 : lu ? LU[i] - 1 : 0;
         nS[i] = cnt_clr ? 0 : (st && sCnt[i] < mx) ? sCnt[i] + 1 : sCnt[i];
         nF[i] = cnt_clr ? 0 : (redirect_x && fCnt[i] < mx) ? fCnt[i] + 1 : fCnt[i];
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         left[i] = rst ? nLeft[i] : 0;
         sCnt[i] = rst ? nS[i] : 0;
         fCnt[i] = rst ? nF[i] : 0;
      end
      @(negedge clk);
   endtask

   initial begin
      idle();
      for (int i = 0; i < 3; i++) begin left[i] = 0; sCnt[i] = 0; fCnt[i] = 0; end
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      // forwarding priority
      rd_m = 5'd5; regwrite_m = 1'b1; rd_w = 5'd5; regwrite_w = 1'b1; rs1_x = 5'd5;
      cycle();
      check("t1_m_prio", fa[0], 1);
      check("t1_nofwd_tied", fa[1], 0);
      regwrite_m = 1'b0;
      cycle();
      check("t1_w_src", fa[0], 2);
      regwrite_m = 1'b1; rd_m = 5'd0; rs1_x = 5'd0;
      cycle();
      check("t1_r0", fa[0], 0);
      // load-use with three bubbles
      idle(); cnt_clr = 1'b1;
      cycle();
      idle(); loadUse();
      cycle();
      idle();
      repeat (5) cycle();
      check("t2_stall_cnt", scA, 3);
      // redirect beats load-use stall
      cnt_clr = 1'b1;
      cycle();
      idle(); loadUse(); redirect_x = 1'b1;
      cycle();
      idle();
      cycle();
      check("t3_flush_cnt", fcA, 1);
      check("t3_stall_cnt", scA, 0);
      // stall-only mode: writer walks X -> M -> W
      for (int r = 0; r < 2; r++) begin
         idle(); cnt_clr = 1'b1;
         cycle();
         idle(); rs1_d = r == 0 ? 5'd3 : 5'd0; use_rs1_d = 1'b1;
         rd_x = rs1_d; regwrite_x = 1'b1;
         cycle();
         rd_x = 5'd0; regwrite_x = 1'b0; rd_m = rs1_d; regwrite_m = 1'b1;
         cycle();
         rd_m = 5'd0; regwrite_m = 1'b0; rd_w = rs1_d; regwrite_w = 1'b1;
         cycle();
         idle();
         cycle();
         check(tg("t4_raw_stalls", r), scB, r == 0 ? 3 : 0);
      end
      // reset asserted during the second bubble of a four-bubble sequence
      idle(); loadUse();
      cycle();
      idle(); rst = 1'b0;
      cycle();
      check("t5_rst_stall", sd[2], 0);
      rst = 1'b1;
      repeat (5) cycle();
      check("t5_no_residual", scC, 0);
      // saturation and clear while stalled
      idle(); loadUse(); rd_m = 5'd8; regwrite_m = 1'b1;
      repeat (20) cycle();
      check("t6_sat_b", scB, 15);
      check("t6_sat_c", scC, 15);
      cnt_clr = 1'b1;
      cycle();
      check("t6_clr_b", scB, 0);
      check("t6_clr_c", scC, 0);
      // randomized traffic with occasional mid-cycle resets
      for (int n = 0; n < 400; n++) begin
         rst = $urandom_range(0, 39) != 0;
         rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
         rs1_x = 5'($urandom_range(0, 3)); rs2_x = 5'($urandom_range(0, 3));
         rd_x = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
         use_rs1_d = 1'($urandom_range(0, 1)); use_rs2_d = 1'($urandom_range(0, 1));
         regwrite_x = 1'($urandom_range(0, 1)); regwrite_m = 1'($urandom_range(0, 1));
         regwrite_w = 1'($urandom_range(0, 1)); memread_x = 1'($urandom_range(0, 1));
         redirect_x = $urandom_range(0, 5) == 0;
         cnt_clr = $urandom_range(0, 29) == 0;
         cycle();
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
